// File: rtl/arm_mem_if.sv
// Handshaked request/response bundle between the ARM32 core's fetch/load-store
// port (master) and a memory responder (slave).
//   req_*  : request channel (valid/ready), byte address, write data, byte enables
//   rsp_*  : response channel (valid/ready), read data, fault flag
interface arm_mem_if #(
  parameter int unsigned ARCH   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [ARCH-1:0]   req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ARCH-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the ARM32 core. Accepts one request at a time,
// performs a word read or byte-enabled write on internal storage LATENCY
// cycles after acceptance, and holds the response until the requester takes it.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset (storage is not cleared)
//   bus   : arm_mem_if slave modport (request and response channels)
//
// Optional feature: define ARM_MEM_ALIGN_CHECK_EN to fault any access whose
// byte address is not word aligned. Without it, addr[1:0] is ignored.
module arm_mem_responder #(
  parameter int unsigned ARCH    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  arm_mem_if.slave     bus
);

  localparam int unsigned LANES  = ARCH / 8;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [MEM_AW-1:0]  idx_q;
  logic [ARCH-1:0]    wdata_q;
  logic [LANES-1:0]   be_q;
  logic               err_q;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ARCH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [ARCH-1:0]    mem [DEPTH];

  logic               accept;
  logic               in_range;
  logic               misaligned;
  logic               req_err;
  logic               commit;
  logic               commit_we;

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Range check on the full word index, before it is truncated to MEM_AW bits.
  assign in_range = ({2'b00, bus.req_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));

`ifdef ARM_MEM_ALIGN_CHECK_EN
  assign misaligned = (bus.req_addr[1:0] != 2'b00);
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus.req_addr[1:0];
  assign misaligned     = 1'b0;
`endif

  assign req_err   = !in_range || misaligned;
  assign commit    = (state_q == StBusy) && (cnt_q == '0);
  // Faulted writes never touch storage.
  assign commit_we = commit && we_q && !err_q && !reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = (we_q || err_q) ? '0 : mem[idx_q];
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        idx_q   <= bus.req_addr[MEM_AW+1:2];
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
        err_q   <= req_err;
      end
    end
  end

  // Storage has no reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (commit_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
